ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 53 +++++
 rtl/ram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles the two requester ports (m0 = core data side, m1 = loader/DMA)
// and the single RAM data port that the arbiter shares between them.
// The "slave" modport is the arbiter's view. The "master" modport is the
// surrounding system's view: both requesters plus the RAM, which returns
// ram_rdata one cycle after it sees an address.

interface ram_port_arbiter_if #(
    parameter int AW = 14
);
    // Requester m0 (core data side)
    logic          m0_req;
    logic [AW-1:0] m0_addr;
    logic [3:0]    m0_wstrb;
    logic [31:0]   m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [31:0]   m0_rdata;

    // Requester m1 (loader / DMA)
    logic          m1_req;
    logic [AW-1:0] m1_addr;
    logic [3:0]    m1_wstrb;
    logic [31:0]   m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [31:0]   m1_rdata;

    // Shared RAM data port
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_wstrb;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    modport slave (
        input  m0_req, m0_addr, m0_wstrb, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_wstrb, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_addr, ram_wstrb, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output m0_req, m0_addr, m0_wstrb, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_wstrb, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_addr, ram_wstrb, ram_wdata,
        output ram_rdata
    );

endinterface : ram_port_arbiter_if

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM data port between the core (m0) and a
// loader/DMA engine (m1). m0 normally wins; a starvation counter forces
// a grant to m1 once m0 has been granted STARVE_MAX times in a row while
// m1 was waiting. Grants are combinational so an access is issued to the
// RAM in the same cycle it is accepted. Read data comes back one cycle
// later and is steered by a registered owner tag; writes never produce
// an rvalid.

module ram_port_arbiter #(
    parameter int AW         = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 resetb,
    ram_port_arbiter_if.slave    bus
);

    // A counter that must reach STARVE_MAX needs ceil(log2(STARVE_MAX+1))
    // bits; keep at least one bit so STARVE_MAX = 0 still elaborates.
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SCNT_LIMIT = SW'(STARVE_MAX);

    // Who issued the read whose data the RAM returns this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } rd_owner_t;

    rd_owner_t     rd_owner;
    rd_owner_t     rd_owner_nxt;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_nxt;

    logic          starved;
    logic          gnt0;
    logic          gnt1;
    logic          m0_is_read;
    logic          m1_is_read;

    logic [AW-1:0] sel_addr;
    logic [3:0]    sel_wstrb;
    logic [31:0]   sel_wdata;

    // A zero strobe mask marks an access as a read.
    assign m0_is_read = (bus.m0_wstrb == 4'b0000);
    assign m1_is_read = (bus.m1_wstrb == 4'b0000);

    // Arbitration: m1 wins when m0 is idle or m1 has waited out its quota;
    // nothing is granted while reset is held.
    always_comb begin
        starved = (scnt == SCNT_LIMIT);
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (resetb) begin
            if (bus.m1_req && (!bus.m0_req || starved)) begin
                gnt1 = 1'b1;
            end else if (bus.m0_req) begin
                gnt0 = 1'b1;
            end
        end
    end

    // Next-state: starvation count and owner of the read now in the RAM.
    always_comb begin
        scnt_nxt     = scnt;
        rd_owner_nxt = OWN_NONE;

        // The count only means something while m1 is actually waiting.
        if (gnt1 || !bus.m1_req) begin
            scnt_nxt = '0;
        end else if (gnt0) begin
            scnt_nxt = scnt + 1'b1;
        end

        // Only granted reads get a return slot; writes leave owner empty.
        if (gnt0 && m0_is_read) begin
            rd_owner_nxt = OWN_M0;
        end else if (gnt1 && m1_is_read) begin
            rd_owner_nxt = OWN_M1;
        end
    end

    // State register; reset also drops any read still in flight.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            scnt     <= '0;
            rd_owner <= OWN_NONE;
        end else begin
            scnt     <= scnt_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end

    // RAM port mux: the granted master passes through untouched; when idle
    // the address/data still follow m0 but the strobes are held at zero.
    always_comb begin
        sel_addr  = bus.m0_addr;
        sel_wdata = bus.m0_wdata;
        sel_wstrb = 4'b0000;
        if (gnt1) begin
            sel_addr  = bus.m1_addr;
            sel_wdata = bus.m1_wdata;
            sel_wstrb = bus.m1_wstrb;
        end else if (gnt0) begin
            sel_wstrb = bus.m0_wstrb;
        end
    end

    assign bus.ram_addr  = sel_addr;
    assign bus.ram_wstrb = sel_wstrb;
    assign bus.ram_wdata = sel_wdata;

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;

    // Read data is broadcast to both masters; rvalid says whose it is.
    assign bus.m0_rdata  = bus.ram_rdata;
    assign bus.m1_rdata  = bus.ram_rdata;
    assign bus.m0_rvalid = (rd_owner == OWN_M0);
    assign bus.m1_rvalid = (rd_owner == OWN_M1);

    // Grants are mutually exclusive by construction.
    always_comb begin
        assert (!(gnt0 && gnt1));
    end

    // The counter never runs past the point where m1 is forced through.
    always_ff @(posedge clk) begin
        if (resetb) begin
            assert (scnt <= SCNT_LIMIT);
        end
    end

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter with a behavioural byte-writable RAM
// that returns data one cycle after the address. Every RAM word starts as
// 32'hA500_0000 | address, so expected read data is known up front.

module tb_ram_port_arbiter;

    localparam int AW = 14;

    logic clk;
    logic resetb;

    int checks;
    int errors;

    logic [31:0] mem [0:(1<<AW)-1];

    ram_port_arbiter_if #(.AW(AW)) bus ();

    ram_port_arbiter #(
        .AW         (AW),
        .STARVE_MAX (4)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: byte-strobed writes, registered read data.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.ram_wstrb[b]) begin
                mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            end
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Drive both requesters at the falling edge, then settle before checks.
    task automatic applyStimulus(
        input logic          r0,
        input logic [AW-1:0] a0,
        input logic [3:0]    s0,
        input logic [31:0]   d0,
        input logic          r1,
        input logic [AW-1:0] a1,
        input logic [3:0]    s1,
        input logic [31:0]   d1
    );
        @(negedge clk);
        bus.m0_req   = r0;
        bus.m0_addr  = a0;
        bus.m0_wstrb = s0;
        bus.m0_wdata = d0;
        bus.m1_req   = r1;
        bus.m1_addr  = a1;
        bus.m1_wstrb = s1;
        bus.m1_wdata = d1;
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 14'h0000, 4'h0, 32'h0, 1'b0, 14'h0000, 4'h0, 32'h0);
    endtask

    // One comparison: count it, and report tag/observed/expected on mismatch.
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'hA500_0000 | i;
        end

        resetb       = 1'b0;
        bus.m0_req   = 1'b0;
        bus.m0_addr  = '0;
        bus.m0_wstrb = '0;
        bus.m0_wdata = '0;
        bus.m1_req   = 1'b0;
        bus.m1_addr  = '0;
        bus.m1_wstrb = '0;
        bus.m1_wdata = '0;

        // Reset held with requests pending: no grants, no writes, no rvalid.
        applyStimulus(1'b1, 14'h0001, 4'hF, 32'h1111_1111, 1'b1, 14'h0002, 4'hF, 32'h2222_2222);
        checkOutput("rst_m0_gnt",    bus.m0_gnt,    32'd0);
        checkOutput("rst_m1_gnt",    bus.m1_gnt,    32'd0);
        checkOutput("rst_ram_wstrb", bus.ram_wstrb, 32'd0);
        checkOutput("rst_m0_rvalid", bus.m0_rvalid, 32'd0);
        checkOutput("rst_m1_rvalid", bus.m1_rvalid, 32'd0);
        idleStep();
        resetb = 1'b1;
        #1;

        // m0 read of 0x0010 alone.
        applyStimulus(1'b1, 14'h0010, 4'h0, 32'h0, 1'b0, 14'h0000, 4'h0, 32'h0);
        checkOutput("rd10_m0_gnt",    bus.m0_gnt,    32'd1);
        checkOutput("rd10_m1_gnt",    bus.m1_gnt,    32'd0);
        checkOutput("rd10_ram_addr",  bus.ram_addr,  32'h0010);
        checkOutput("rd10_ram_wstrb", bus.ram_wstrb, 32'd0);
        // Idle with junk on m0's inputs: no grant, wstrb forced low, addr follows m0.
        applyStimulus(1'b0, 14'h3FFF, 4'hF, 32'hCAFE_F00D, 1'b0, 14'h0000, 4'h0, 32'h0);
        checkOutput("rd10_m0_rvalid",  bus.m0_rvalid, 32'd1);
        checkOutput("rd10_m0_rdata",   bus.m0_rdata,  32'hA500_0010);
        checkOutput("rd10_m1_rvalid",  bus.m1_rvalid, 32'd0);
        checkOutput("idle_m0_gnt",     bus.m0_gnt,    32'd0);
        checkOutput("idle_ram_wstrb",  bus.ram_wstrb, 32'd0);
        checkOutput("idle_ram_addr",   bus.ram_addr,  32'h3FFF);
        idleStep();
        checkOutput("rd10_rvalid_once", bus.m0_rvalid, 32'd0);

        // m1 partial write, then m0 reads it back.
        applyStimulus(1'b0, 14'h0100, 4'hF, 32'h0, 1'b1, 14'h0020, 4'b0011, 32'hDEAD_BEEF);
        checkOutput("wr20_m1_gnt",    bus.m1_gnt,    32'd1);
        checkOutput("wr20_m0_gnt",    bus.m0_gnt,    32'd0);
        checkOutput("wr20_ram_wstrb", bus.ram_wstrb, 32'h3);
        checkOutput("wr20_ram_addr",  bus.ram_addr,  32'h0020);
        checkOutput("wr20_ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 14'h0020, 4'h0, 32'h0, 1'b0, 14'h0000, 4'h0, 32'h0);
        checkOutput("wr20_no_m1_rvalid", bus.m1_rvalid, 32'd0);
        checkOutput("wr20_no_m0_rvalid", bus.m0_rvalid, 32'd0);
        checkOutput("rd20_m0_gnt",       bus.m0_gnt,    32'd1);
        idleStep();
        checkOutput("rd20_m0_rvalid", bus.m0_rvalid, 32'd1);
        checkOutput("rd20_m0_rdata",  bus.m0_rdata,  32'hA500_BEEF);

        // Back-to-back reads alternating m0, m1, m0.
        applyStimulus(1'b1, 14'h0030, 4'h0, 32'h0, 1'b0, 14'h0000, 4'h0, 32'h0);
        checkOutput("alt_a_m0_gnt", bus.m0_gnt, 32'd1);
        applyStimulus(1'b0, 14'h0000, 4'h0, 32'h0, 1'b1, 14'h0031, 4'h0, 32'h0);
        checkOutput("alt_b_m1_gnt",    bus.m1_gnt,    32'd1);
        checkOutput("alt_b_m0_rvalid", bus.m0_rvalid, 32'd1);
        checkOutput("alt_b_m0_rdata",  bus.m0_rdata,  32'hA500_0030);
        applyStimulus(1'b1, 14'h0032, 4'h0, 32'h0, 1'b0, 14'h0000, 4'h0, 32'h0);
        checkOutput("alt_c_m0_gnt",    bus.m0_gnt,    32'd1);
        checkOutput("alt_c_m1_rvalid", bus.m1_rvalid, 32'd1);
        checkOutput("alt_c_m0_rvalid", bus.m0_rvalid, 32'd0);
        checkOutput("alt_c_m1_rdata",  bus.m1_rdata,  32'hA500_0031);
        idleStep();
        checkOutput("alt_d_m0_rvalid", bus.m0_rvalid, 32'd1);
        checkOutput("alt_d_m1_rvalid", bus.m1_rvalid, 32'd0);
        checkOutput("alt_d_m0_rdata",  bus.m0_rdata,  32'hA500_0032);

        // Both requesting continuously: m0 x4 then m1, repeating.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 14'h0040, 4'h0, 32'h0, 1'b1, 14'h0041, 4'h0, 32'h0);
            checkOutput($sformatf("starve_m1_gnt_%0d", i), bus.m1_gnt, 32'((i % 5) == 4));
            checkOutput($sformatf("starve_m0_gnt_%0d", i), bus.m0_gnt, 32'((i % 5) != 4));
            if (i > 0) begin
                checkOutput($sformatf("starve_m1_rvalid_%0d", i), bus.m1_rvalid,
                            32'(((i - 1) % 5) == 4));
            end
        end
        idleStep();

        // m1 backs off after 3 m0 grants; its wait restarts from zero.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 14'h0042, 4'h0, 32'h0, 1'b1, 14'h0043, 4'h0, 32'h0);
            checkOutput($sformatf("drop_pre_m0_gnt_%0d", i), bus.m0_gnt, 32'd1);
        end
        applyStimulus(1'b1, 14'h0042, 4'h0, 32'h0, 1'b0, 14'h0043, 4'h0, 32'h0);
        checkOutput("drop_gap_m0_gnt", bus.m0_gnt, 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 14'h0042, 4'h0, 32'h0, 1'b1, 14'h0043, 4'h0, 32'h0);
            checkOutput($sformatf("drop_post_m1_gnt_%0d", i), bus.m1_gnt, 32'(i == 4));
        end
        idleStep();

        // Reset in the cycle after a granted m1 read.
        applyStimulus(1'b0, 14'h0000, 4'h0, 32'h0, 1'b1, 14'h0050, 4'h0, 32'h0);
        checkOutput("rstfly_m1_gnt", bus.m1_gnt, 32'd1);
        applyStimulus(1'b1, 14'h0060, 4'hF, 32'h1234_5678, 1'b0, 14'h0000, 4'h0, 32'h0);
        resetb = 1'b0;
        #1;
        checkOutput("rstfly_m1_rvalid", bus.m1_rvalid, 32'd0);
        checkOutput("rstfly_ram_wstrb", bus.ram_wstrb, 32'd0);
        checkOutput("rstfly_m0_gnt",    bus.m0_gnt,    32'd0);
        applyStimulus(1'b1, 14'h0060, 4'hF, 32'h1234_5678, 1'b0, 14'h0000, 4'h0, 32'h0);
        checkOutput("rstfly_hold_wstrb", bus.ram_wstrb, 32'd0);
        idleStep();
        resetb = 1'b1;
        #1;
        checkOutput("rstfly_rel_m1_rvalid", bus.m1_rvalid, 32'd0);
        // A cleared counter means four m0 grants before m1 gets through.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 14'h0061, 4'h0, 32'h0, 1'b1, 14'h0062, 4'h0, 32'h0);
            checkOutput($sformatf("rstfly_m1_gnt_%0d", i), bus.m1_gnt, 32'(i == 4));
        end
        // The write held during reset must not have reached the RAM.
        applyStimulus(1'b1, 14'h0060, 4'h0, 32'h0, 1'b0, 14'h0000, 4'h0, 32'h0);
        idleStep();
        checkOutput("rstfly_rd60_rvalid", bus.m0_rvalid, 32'd1);
        checkOutput("rstfly_rd60_rdata",  bus.m0_rdata,  32'hA500_0060);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_port_arbiter
